ps2_rx: RTL
===========

# ps2_rx

Receives device-to-host PS/2 frames (start, 8 data LSB-first, odd parity, stop) from the open-collector `ps2_clk`/`ps2_data` lines and delivers each byte with a one-cycle valid strobe. It sits beside the host-to-device transmitter on the same two lines, downstream of the pins and upstream of the display/decode logic in `top`. It yields to the transmitter through `inhibit` and exports `busyRead` so the transmitter does not start a `send` while a device frame is in flight.

## Interface
- `FILTER_LEN`, 8: consecutive `ck` cycles a synchronized `ps2_clk` level must hold before the filtered clock changes; minimum 2.
- `TIMEOUT`, 200000: `ck` cycles allowed between filtered falling edges inside a frame, which is 2 ms at 100 MHz.
- `ck`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high; sampled on rising `ck`.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `inhibit`  in  1  high while the transmitter owns the bus; aborts and holds the receiver idle.
- `rx_data`  out  8  last good byte; changes only on a good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new in the same cycle.
- `rx_err`  out  1  one-cycle pulse on parity error, bad stop bit or timeout.
- `busyRead`  out  1  high while a frame is being received.

## Operation
- **Synchronizers:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
- **Clock filter:**
  - The filtered clock `fclk` resets to 1.
  - A counter increments while the synchronized clock differs from `fclk` and clears when they match.
  - When the counter reaches `FILTER_LEN`-1 and the levels still differ, `fclk` takes the new level and the counter clears.
- **Falling-edge strobe:** `fall` = `fclk_prev`=1 and `fclk`=0, with `fclk_prev` reset to 1. On `fall`, the synchronized data bit is sampled.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: `fall` with data=0 goes to DATA with bit count 0. `fall` with data=1 is ignored and stays in IDLE with no error.
  - DATA: each `fall` shifts the bit into `shreg[bitcnt]`, LSB first. The 8th bit goes to PARITY.
  - PARITY: `fall` stores the parity bit and goes to STOP.
  - STOP: `fall` returns to IDLE. If stop=1 and the ones-count over 8 data bits plus parity is odd, load `rx_data` and pulse `rx_valid`. Otherwise pulse `rx_err` and leave `rx_data` unchanged.
- **Timeout:**
  - The timeout counter clears on every `fall` and in IDLE, and counts every cycle otherwise.
  - Reaching `TIMEOUT` in a non-IDLE state goes to IDLE and pulses `rx_err`.
- **Inhibit:** while `inhibit`=1 the FSM is forced to IDLE and the partial frame is discarded, with no `rx_err`. The filter and synchronizers keep running.
- `busyRead` = (state != IDLE), registered with the state.
- **Priorities, highest first:** `reset` > `inhibit` > `fall` > timeout.
  - `fall` and timeout in the same cycle: the edge is processed and the timeout counter clears.
  - `inhibit` in the same cycle as the stop-bit `fall`: no `rx_valid`, no `rx_err`.

## Timing
- **Reset values:** `rx_data`=8'h00, `rx_valid`=0, `rx_err`=0, `busyRead`=0, state IDLE, `fclk`=1, `fclk_prev`=1, all counters 0.
- **Edge latency:** a raw `ps2_clk` fall that is stable thereafter produces `fall` at rising edge `FILTER_LEN`+2 after the pin change (2 sync + filter). The FSM updates at edge `FILTER_LEN`+3.
- **Frame output latency:** `rx_valid`/`rx_err` are registered. They are high for exactly one cycle, starting at edge `FILTER_LEN`+3 after the raw stop-bit clock fall, and `rx_data` updates on that same edge.
- **Glitches:** a `ps2_clk` low pulse shorter than `FILTER_LEN` cycles (after sync) produces no `fall`.
- **busyRead:** rises on the edge that processes the start-bit `fall` and falls on the edge that processes the stop `fall`, the timeout, or `inhibit`.
- There is no back-pressure. A consumer must capture `rx_data` on `rx_valid`. Consecutive frames are ≥ 11 PS/2 clock periods apart.

## Test plan
Bench runs with `FILTER_LEN`=4 and `TIMEOUT`=1000, PS/2 clock half-period 50 `ck` cycles, and data changed mid-high.
- Frame 0xEE, parity 1, stop 1 -> one `rx_valid` pulse 7 cycles after the stop-bit clock fall, `rx_data`=0xEE, `rx_err`=0. `busyRead` is high from the start bit to the stop bit.
- Back-to-back frames 0x00 (parity 1) then 0x01 (parity 0) -> two `rx_valid` pulses, giving `rx_data` 0x00 then 0x01.
- Frame 0x55 with parity 0, and separately 0xAA with stop 0 -> one `rx_err` pulse each, no `rx_valid`, `rx_data` keeps its prior value, `busyRead` returns to 0.
- 3-cycle low glitch on `ps2_clk` with `ps2_data`=0 -> no state change, `busyRead` stays 0, no pulses.
- Start bit plus 3 data bits, then the clock is held high -> `rx_err` pulse exactly 1000 cycles after the last filtered fall, `busyRead` drops, and a following 0xFA frame is received correctly.
- Two cases:
  - `inhibit` pulsed high mid-frame -> `busyRead` 0 on the next edge, no pulses.
  - `reset` asserted mid-frame -> all outputs return to reset values, and the next full frame 0x1C is received correctly.

Source files
------------

// File: rtl/ps2_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_if
//  Description : Receive-side result bus of the PS/2 receiver: the received
//                byte, its valid/error strobes and the frame-in-flight flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busyRead;

    // The receiver drives the bus, downstream consumers observe it.
    modport master (output rx_data, output rx_valid, output rx_err, output busyRead);
    modport slave  (input  rx_data, input  rx_valid, input  rx_err, input  busyRead);
endinterface
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host frame receiver. Synchronizes and
//                glitch-filters the PS/2 clock, samples data on filtered
//                falling edges, checks odd parity and stop bit, and reports
//                each byte with a one-cycle valid or error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic     ck,
    input  logic     reset,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    input  logic     inhibit,
    ps2_rx_if.master rx
);

    localparam int                    c_FCNT_W    = $clog2(FILTER_LEN) + 1;
    localparam logic [c_FCNT_W-1:0]   c_FCNT_LAST = c_FCNT_W'(FILTER_LEN - 1);
    localparam int                    c_TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TCNT_W-1:0]   c_TCNT_LAST = c_TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic                r_clk_meta, r_clk_sync;
    logic                r_dat_meta, r_dat_sync;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic                r_fclk, r_fclk_prev;
    logic                w_fall;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_bitcnt, w_bitcnt_nxt;
    logic [7:0]          r_shreg, w_shreg_nxt;
    logic                r_par, w_par_nxt;
    logic [c_TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
    logic                w_tmo;
    logic [7:0]          r_rx_data, w_rx_data_nxt;
    logic                r_rx_valid, w_rx_valid_nxt;
    logic                r_rx_err, w_rx_err_nxt;
    logic                r_busy;

    // Two-flop synchronizers for both pins; reset to the idle bus level.
    always_ff @(posedge ck) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Clock filter: the new level must persist FILTER_LEN cycles before fclk follows.
    always_ff @(posedge ck) begin
        if (reset) begin
            r_fcnt      <= '0;
            r_fclk      <= 1'b1;
            r_fclk_prev <= 1'b1;
        end else begin
            r_fclk_prev <= r_fclk;
            if (r_clk_sync != r_fclk) begin
                if (r_fcnt == c_FCNT_LAST) begin
                    r_fclk <= r_clk_sync;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall = r_fclk_prev & ~r_fclk;

    // Fires one cycle early so the abort lands on the edge the count would reach TIMEOUT.
    assign w_tmo  = (r_tcnt == c_TCNT_LAST);

    // Frame FSM next state and outputs; priority is inhibit, then edge, then timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_bitcnt_nxt   = r_bitcnt;
        w_shreg_nxt    = r_shreg;
        w_par_nxt      = r_par;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_rx_err_nxt   = 1'b0;
        w_tcnt_nxt     = (r_state == ST_IDLE || w_fall) ? '0 : r_tcnt + 1'b1;

        if (inhibit) begin
            w_state_nxt = ST_IDLE;
            w_tcnt_nxt  = '0;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    // A high start bit is line noise, not a frame.
                    if (!r_dat_sync) begin
                        w_state_nxt  = ST_DATA;
                        w_bitcnt_nxt = 3'd0;
                    end
                end
                ST_DATA: begin
                    w_shreg_nxt[r_bitcnt] = r_dat_sync;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    w_par_nxt   = r_dat_sync;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (r_dat_sync && (^{r_shreg, r_par})) begin
                        w_rx_data_nxt  = r_shreg;
                        w_rx_valid_nxt = 1'b1;
                    end else begin
                        w_rx_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE && w_tmo) begin
            w_state_nxt  = ST_IDLE;
            w_rx_err_nxt = 1'b1;
            w_tcnt_nxt   = '0;
        end
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge ck) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 3'd0;
            r_shreg    <= 8'h00;
            r_par      <= 1'b0;
            r_tcnt     <= '0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_par      <= w_par_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_err   <= w_rx_err_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign rx.rx_data  = r_rx_data;
    assign rx.rx_valid = r_rx_valid;
    assign rx.rx_err   = r_rx_err;
    assign rx.busyRead = r_busy;

endmodule
`default_nettype wire
